// File: rtl/cpu_datapath_if.sv
// Signal bundle between the cpu control FSM / bench (master) and cpu_datapath (slave).
// result_valid is a one-cycle pulse with no ready: the consumer must accept it on that cycle.
interface cpu_datapath_if #(
  parameter int DATA_W = 16
);
  logic [2:0]        mux_sel;
  logic [2:0]        sel;
  logic              en_s;
  logic              en_c;
  logic [7:0]        en;
  logic              done;
  logic              ld_en;
  logic [2:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              zero;
  logic              carry;
  logic [15:0]       inst_count;

  modport master (
    output mux_sel, sel, en_s, en_c, en, done, ld_en, ld_addr, ld_data, dbg_addr,
    input  bus, dbg_data, result, result_valid, zero, carry, inst_count
  );

  modport slave (
    input  mux_sel, sel, en_s, en_c, en, done, ld_en, ld_addr, ld_data, dbg_addr,
    output bus, dbg_data, result, result_valid, zero, carry, inst_count
  );
endinterface

// File: rtl/cpu_datapath.sv
// Register file R0..R7, bus mux, operand register S, ALU and result register C.
// Executes Rdst <= Rdst op Rsrc under control of the external S0->S1->S2 sequencer.
module cpu_datapath #(
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  cpu_datapath_if.slave  dp
);
  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] result_q;
  logic              result_valid_q;
  logic              zero_q;
  logic              carry_q;
  logic [15:0]       inst_count_q;

  logic [DATA_W-1:0] bus_w;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;

  assign bus_w           = r_q[dp.mux_sel];
  assign dp.bus          = bus_w;
  assign dp.dbg_data     = r_q[dp.dbg_addr];
  assign dp.result       = result_q;
  assign dp.result_valid = result_valid_q;
  assign dp.zero         = zero_q;
  assign dp.carry        = carry_q;
  assign dp.inst_count   = inst_count_q;

  // ALU: A is the operand register S, B is the live bus value.
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    case (dp.sel)
      3'd0: {alu_c, alu_y} = {1'b0, s_q} + {1'b0, bus_w};
      3'd1: begin
        alu_y = s_q - bus_w;
        alu_c = (s_q < bus_w);
      end
      3'd2: alu_y = s_q & bus_w;
      3'd3: alu_y = s_q | bus_w;
      3'd4: alu_y = s_q ^ bus_w;
      3'd5: begin
        alu_y = {s_q[DATA_W-2:0], 1'b0};
        alu_c = s_q[DATA_W-1];
      end
      3'd6: begin
        alu_y = {1'b0, s_q[DATA_W-1:1]};
        alu_c = s_q[0];
      end
      default: alu_y = bus_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
      s_q            <= '0;
      c_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      zero_q         <= 1'b0;
      carry_q        <= 1'b0;
      inst_count_q   <= '0;
    end else begin
      // A write-back enable beats an external load aimed at the same register.
      for (int i = 0; i < 8; i++) begin
        if (dp.en[i]) begin
          r_q[i] <= c_q;
        end else if (dp.ld_en && (dp.ld_addr == 3'(i))) begin
          r_q[i] <= dp.ld_data;
        end
      end
      if (dp.en_s) s_q <= bus_w;
      if (dp.en_c) begin
        c_q     <= alu_y;
        zero_q  <= (alu_y == '0);
        carry_q <= alu_c;
      end
      result_valid_q <= dp.done;
      if (dp.done) begin
        result_q     <= c_q;
        inst_count_q <= inst_count_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized scoreboard bench for cpu_datapath against an arithmetic reference model.
module tb_cpu_datapath;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_datapath_if #(.DATA_W(16)) dp ();
  cpu_datapath #(.DATA_W(16)) dut (.clk(clk), .reset(reset), .dp(dp));

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  int unsigned m_r[8];
  int unsigned m_s, m_c, m_cnt;
  bit m_z, m_cy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU with plain integer arithmetic on 16-bit values.
  function automatic void alu_ref(input int unsigned a, input int unsigned b, input int op,
                                  output int unsigned y, output bit c);
    int unsigned t;
    c = 1'b0;
    case (op)
      0: begin t = a + b; y = t % 65536; c = (t >= 65536); end
      1: begin y = (a + 65536 - b) % 65536; c = (a < b); end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: begin t = a * 2; y = t % 65536; c = (t >= 65536); end
      6: begin y = a / 2; c = (a % 2) == 1; end
      default: y = b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_s = 0; m_c = 0; m_cnt = 0; m_z = 0; m_cy = 0;
  endtask

  task automatic idle_inputs();
    dp.mux_sel = 3'd0; dp.sel = 3'd0; dp.en_s = 1'b0; dp.en_c = 1'b0;
    dp.en = 8'h00; dp.done = 1'b0; dp.ld_en = 1'b0; dp.ld_addr = 3'd0;
    dp.ld_data = 16'h0000; reset = 1'b0;
  endtask

  // One clock of stimulus; the model advances alongside the DUT.
  task automatic cyc(input bit rst, input logic [2:0] ms, input logic [2:0] op,
                     input bit es, input bit ec, input logic [7:0] e, input bit dn,
                     input bit le, input logic [2:0] la, input logic [15:0] ld);
    int unsigned y, bv;
    bit c;
    reset = rst; dp.mux_sel = ms; dp.sel = op; dp.en_s = es; dp.en_c = ec;
    dp.en = e; dp.done = dn; dp.ld_en = le; dp.ld_addr = la; dp.ld_data = ld;
    bv = m_r[ms];
    alu_ref(m_s, bv, int'(op), y, c);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (dn) begin
        exp_q.push_back(16'(m_c));
        m_cnt = (m_cnt + 1) % 65536;
      end
      for (int i = 0; i < 8; i++) begin
        if (e[i]) m_r[i] = m_c;
        else if (le && la == 3'(i)) m_r[i] = ld;
      end
      if (es) m_s = bv;
      if (ec) begin m_c = y; m_z = (y == 0); m_cy = c; end
    end
    idle_inputs();
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 1, a, d);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, ".zero"}, 32'(dp.zero), 32'(m_z));
    chk({tag, ".carry"}, 32'(dp.carry), 32'(m_cy));
    chk({tag, ".inst_count"}, 32'(dp.inst_count), m_cnt);
  endtask

  // Executes Rdst <= Rdst op Rsrc over S0, S1, S2.
  task automatic instr(input logic [2:0] dst, input logic [2:0] src, input logic [2:0] op);
    cyc(0, dst, 0, 1, 0, 8'h00, 0, 0, 0, 0);
    cyc(0, src, op, 0, 1, 8'h00, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 8'(1 << dst), 1, 0, 0, 0);
    check_flags("instr");
  endtask

  task automatic check_reg(input int i);
    @(negedge clk);
    dp.dbg_addr = 3'(i);
    #1;
    chk($sformatf("R%0d", i), 32'(dp.dbg_data), m_r[i]);
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 8; i++) check_reg(i);
  endtask

  // Monitor: every result_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (dp.result_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result_valid actual result=%h expected no pulse at %0t",
                 dp.result, $time);
      end else begin
        logic [15:0] exp;
        exp = exp_q.pop_front();
        if (dp.result !== exp) begin
          errors++;
          $display("FAIL result actual=%h expected=%h at %0t", dp.result, exp, $time);
        end
      end
    end
  end

  initial begin
    dp.dbg_addr = 3'd0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Reset clears a preloaded register, flags and counters.
    load(3, 16'h1234);
    check_reg(3);
    chk("R3_preload", 32'(dp.dbg_data), 32'h1234);
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    chk("reset.result_valid", 32'(dp.result_valid), 32'h0);
    chk("reset.result", 32'(dp.result), 32'h0);
    check_flags("reset");
    check_all_regs();
    cyc(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);

    // ADD
    load(1, 16'h0005); load(2, 16'h0007);
    instr(1, 2, 0);
    check_reg(1);
    chk("add.R1", 32'(dp.dbg_data), 32'h000C);

    // SUB with borrow, then self-subtract to zero
    load(4, 16'h0003); load(5, 16'h0005);
    instr(4, 5, 1);
    chk("sub.carry", 32'(dp.carry), 32'h1);
    check_reg(4);
    chk("sub.R4", 32'(dp.dbg_data), 32'hFFFE);
    instr(5, 5, 1);
    chk("sub0.zero", 32'(dp.zero), 32'h1);
    check_reg(5);

    // Shifts and add overflow
    load(0, 16'h8001); instr(0, 0, 5); check_reg(0);
    chk("shl.R0", 32'(dp.dbg_data), 32'h0002);
    load(1, 16'h0003); instr(1, 1, 6); check_reg(1);
    load(2, 16'hFFFF); load(3, 16'h0001); instr(2, 3, 0); check_reg(2);
    chk("add_ovf.zero_carry", {30'd0, dp.zero, dp.carry}, 32'h3);

    // Write-back vs load conflicts and multi-register write-back
    load(1, 16'h5555);
    cyc(0, 1, 0, 1, 0, 8'h00, 0, 0, 0, 0);
    cyc(0, 1, 7, 0, 1, 8'h00, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 8'h40, 0, 1, 6, 16'hAAAA);
    check_reg(6);
    chk("conflict.R6", 32'(dp.dbg_data), 32'h5555);
    cyc(0, 0, 0, 0, 0, 8'h40, 0, 1, 2, 16'h1357);
    check_reg(2);
    chk("other_load.R2", 32'(dp.dbg_data), 32'h1357);
    load(7, 16'h0BAD);
    cyc(0, 0, 0, 0, 0, 8'hC0, 0, 0, 0, 0);
    check_reg(6); check_reg(7);

    // en_s and en_c together: C uses the old S
    load(4, 16'h0100); load(5, 16'h0020);
    cyc(0, 4, 0, 1, 0, 8'h00, 0, 0, 0, 0);
    cyc(0, 5, 0, 1, 1, 8'h00, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    cyc(0, 5, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    check_flags("same_cycle");

    // Randomized mix of loads, instructions and held done strobes
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: load(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
        1: begin
          cyc(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
          cyc(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        end
        default: instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)));
      endcase
    end
    check_all_regs();

    // Instruction counter wrap
    cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int n = 0; n < 65536; n++) begin
      cyc(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
      if (n == 65534) chk("count_ffff", 32'(dp.inst_count), 32'hFFFF);
    end
    check_flags("wrap");

    // Reset during S1 with done also high: nothing completes
    load(2, 16'h0042);
    cyc(0, 2, 0, 1, 0, 8'h00, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 1, 8'h04, 1, 0, 0, 0);
    chk("mid_reset.result_valid", 32'(dp.result_valid), 32'h0);
    repeat (3) cyc(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    check_flags("mid_reset");
    check_all_regs();

    repeat (3) @(posedge clk);
    #1;
    chk("pending_results", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
